// File: rtl/dvid_timing_pkg.sv
// Shared constants and types for the DVI-D timing sequencer (640x480@60 defaults).
package dvid_timing_pkg;

    // Default 640x480@60 timing, in pixels and lines
    localparam int DEF_DIV      = 5;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;

    localparam int DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

    // Counter width covers totals up to 1024
    localparam int CNT_W = 10;
    localparam int PAT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/dvid_pix_div.sv
// Free-running pixel divider: pix_stb marks the last clk_x5 cycle of each pixel.
module dvid_pix_div
    import dvid_timing_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk_x5,
    input  logic rst_n,
    output logic pix_stb
);

    localparam int DIV_W = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div;

    // Count 0..DIV-1 and wrap; runs regardless of sequencer state
    always_ff @(posedge clk_x5 or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (div == DIV_MAX) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign pix_stb = (div == DIV_MAX);

endmodule

// File: rtl/dvid_timing_sequencer.sv
// DVI-D timing sequencer: pixel strobe, h/v counters, sync/de decode and
// frame-synchronous start/stop and pattern selection, all in the clk_x5 domain.
module dvid_timing_sequencer
    import dvid_timing_pkg::*;
#(
    parameter int DIV      = DEF_DIV,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP
) (
    input  logic             clk_x5,
    input  logic             rst_n,
    input  logic             enable,
    output logic             pix_stb,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame_start,
    input  logic             sel_req,
    input  logic [PAT_W-1:0] sel_val,
    output logic             sel_ack,
    output logic [PAT_W-1:0] pattern
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("dvid_timing_sequencer: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (DIV < 2) begin : g_div_check
        $error("dvid_timing_sequencer: DIV must be at least 2");
    end

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // One extra bit so window ends equal to 1024 still compare correctly
    localparam int EXT_W = CNT_W + 1;
    localparam logic [EXT_W-1:0] H_SYNC_END = EXT_W'(H_SYNC);
    localparam logic [EXT_W-1:0] H_DE_LO    = EXT_W'(H_SYNC + H_BP);
    localparam logic [EXT_W-1:0] H_DE_HI    = EXT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [EXT_W-1:0] V_SYNC_END = EXT_W'(V_SYNC);
    localparam logic [EXT_W-1:0] V_DE_LO    = EXT_W'(V_SYNC + V_BP);
    localparam logic [EXT_W-1:0] V_DE_HI    = EXT_W'(V_SYNC + V_BP + V_ACTIVE);

    // Returns {hsync, vsync, de} for a counter position; all low when not producing
    function automatic logic [2:0] decode_syncs(input logic running,
                                                input logic [CNT_W-1:0] h,
                                                input logic [CNT_W-1:0] v);
        logic [EXT_W-1:0] he;
        logic [EXT_W-1:0] ve;
        logic             hs;
        logic             vs;
        logic             da;
        he = {1'b0, h};
        ve = {1'b0, v};
        hs = (he < H_SYNC_END);
        vs = (ve < V_SYNC_END);
        da = (he >= H_DE_LO) && (he < H_DE_HI) && (ve >= V_DE_LO) && (ve < V_DE_HI);
        return running ? {hs, vs, da} : 3'b000;
    endfunction

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] hc_nxt;
    logic [CNT_W-1:0] vc_nxt;
    logic             hsync_nxt;
    logic             vsync_nxt;
    logic             de_nxt;
    logic             frame_wrap;
    logic             boundary;
    logic             accept;
    logic             fs_nxt;

    dvid_pix_div #(
        .DIV(DIV)
    ) u_pix_div (
        .clk_x5 (clk_x5),
        .rst_n  (rst_n),
        .pix_stb(pix_stb)
    );

    // Next state, counter advance, frame boundary and handshake acceptance
    always_comb begin
        state_nxt  = state;
        hc_nxt     = hc;
        vc_nxt     = vc;
        boundary   = 1'b0;
        frame_wrap = (hc == H_LAST) && (vc == V_LAST);
        if (pix_stb) begin
            case (state)
                IDLE: begin
                    // Counters already sit at (0,0); starting is itself a boundary
                    if (enable) begin
                        state_nxt = RUN;
                        boundary  = 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    boundary = frame_wrap;
                    if (hc == H_LAST) begin
                        hc_nxt = '0;
                        vc_nxt = (vc == V_LAST) ? '0 : vc + 1'b1;
                    end else begin
                        hc_nxt = hc + 1'b1;
                    end
                    // Stopping only takes effect once the frame has wrapped
                    if (frame_wrap && !enable) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = enable ? RUN : DRAIN;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    hc_nxt    = '0;
                    vc_nxt    = '0;
                end
            endcase
        end
        accept = sel_req && ((state == IDLE) || boundary);
        fs_nxt = boundary && enable;
        {hsync_nxt, vsync_nxt, de_nxt} = decode_syncs(state_nxt != IDLE, hc_nxt, vc_nxt);
    end

    // Register state and every timing output together so they move with zero skew
    always_ff @(posedge clk_x5 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hc          <= '0;
            vc          <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            sel_ack     <= 1'b0;
            pattern     <= '0;
        end else begin
            state       <= state_nxt;
            hc          <= hc_nxt;
            vc          <= vc_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            de          <= de_nxt;
            frame_start <= fs_nxt;
            sel_ack     <= accept;
            if (accept) begin
                pattern <= sel_val;
            end
        end
    end

endmodule

// File: tb/tb_dvid_timing_sequencer.sv
// Bench for dvid_timing_sequencer using a reduced raster (13x10 pixels, DIV=5).
module tb_dvid_timing_sequencer;

    localparam int DIV = 5;
    localparam int HS = 3, HBP = 2, HA = 6, HFP = 2;
    localparam int VS = 2, VBP = 2, VA = 4, VFP = 2;
    localparam int HT = HS + HBP + HA + HFP;   // 13
    localparam int VT = VS + VBP + VA + VFP;   // 10
    localparam int FRAME = HT * VT;            // 130 pixels

    logic       clk_x5;
    logic       rst_n;
    logic       enable;
    logic       pix_stb;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       frame_start;
    logic       sel_req;
    logic [2:0] sel_val;
    logic       sel_ack;
    logic [2:0] pattern;

    int errors = 0;
    int checks = 0;

    dvid_timing_sequencer #(
        .DIV(DIV), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
        .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP)
    ) dut (
        .clk_x5     (clk_x5),
        .rst_n      (rst_n),
        .enable     (enable),
        .pix_stb    (pix_stb),
        .hc         (hc),
        .vc         (vc),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .frame_start(frame_start),
        .sel_req    (sel_req),
        .sel_val    (sel_val),
        .sel_ack    (sel_ack),
        .pattern    (pattern)
    );

    initial clk_x5 = 1'b0;
    always #5 clk_x5 = ~clk_x5;

    // Behavioural model: a running flag plus a linear pixel index within the frame
    int       m_k;
    bit       m_act;
    int       m_p;
    bit       m_fs;
    bit       m_ack;
    logic [2:0] m_pat;
    int       cyc;

    initial begin
        m_k = 0; m_act = 0; m_p = 0; m_fs = 0; m_ack = 0; m_pat = '0; cyc = 0;
        forever begin
            @(posedge clk_x5 or negedge rst_n);
            if (!rst_n) begin
                m_k = 0; m_act = 0; m_p = 0; m_fs = 0; m_ack = 0; m_pat = '0;
            end else begin : model_step
                bit stb;
                bit bnd;
                stb = ((m_k % DIV) == DIV - 1);
                bnd = stb && (m_act ? (m_p == FRAME - 1) : enable);
                m_ack = 1'b0;
                if (sel_req && (!m_act || bnd)) begin
                    m_pat = sel_val;
                    m_ack = 1'b1;
                end
                m_fs = bnd && enable;
                if (stb) begin
                    if (!m_act) begin
                        if (enable) begin
                            m_act = 1'b1;
                            m_p   = 0;
                        end
                    end else begin
                        m_p = (m_p + 1) % FRAME;
                        if (m_p == 0 && !enable) m_act = 1'b0;
                    end
                end
                m_k++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_x5);
            cyc++;
        end
    end

    // Observations used by the literal checks
    int fs_q[$];
    int hs_rise_q[$];
    int hs_run = 0, last_hs_len = -1, vs_run = 0, last_vs_len = -1;
    int de_first_hc = -1, de_first_vc = -1, de_fall_hc = -1;
    int max_hc = 0, ack_cnt = 0;
    bit vc_wrap = 0;
    bit hs_prev = 0, vs_prev = 0, de_prev = 0;
    int vc_prev = 0;

    // Per-cycle compare against the model, then record observations
    initial begin
        forever begin
            @(negedge clk_x5);
            begin : compare
                int eh, ev;
                bit ehs, evs, ede, estb;
                logic [28:0] act, exp_v;
                eh   = m_act ? (m_p % HT) : 0;
                ev   = m_act ? (m_p / HT) : 0;
                ehs  = m_act && (eh < HS);
                evs  = m_act && (ev < VS);
                ede  = m_act && (eh >= HS + HBP) && (eh < HS + HBP + HA) &&
                       (ev >= VS + VBP) && (ev < VS + VBP + VA);
                estb = ((m_k % DIV) == DIV - 1);
                act   = {pix_stb, hc, vc, hsync, vsync, de, frame_start, sel_ack, pattern};
                exp_v = {estb, 10'(eh), 10'(ev), ehs, evs, ede, m_fs, m_ack, m_pat};
                checks++;
                if (act !== exp_v) begin
                    errors++;
                    $display("FAIL cycle_compare cyc=%0d actual=%h required=%h (stb,hc,vc,hs,vs,de,fs,ack,pat)",
                             cyc, act, exp_v);
                end
            end
            if (frame_start) fs_q.push_back(cyc);
            if (hsync && !hs_prev) hs_rise_q.push_back(cyc);
            if (hsync) hs_run++;
            else begin
                if (hs_prev) last_hs_len = hs_run;
                hs_run = 0;
            end
            if (vsync) vs_run++;
            else begin
                if (vs_prev) last_vs_len = vs_run;
                vs_run = 0;
            end
            if (de && !de_prev && de_first_hc < 0) begin
                de_first_hc = int'(hc);
                de_first_vc = int'(vc);
            end
            if (!de && de_prev && de_fall_hc < 0) de_fall_hc = int'(hc);
            if (int'(hc) > max_hc) max_hc = int'(hc);
            if (vc_prev == VT - 1 && vc == 0) vc_wrap = 1'b1;
            if (sel_ack) ack_cnt++;
            hs_prev = hsync;
            vs_prev = vsync;
            de_prev = de;
            vc_prev = int'(vc);
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Advance to 2 time units after the n-th next rising edge
    task automatic step(input int n);
        repeat (n) @(posedge clk_x5);
        #2;
    endtask

    task automatic wait_hv(input int h, input int v, input int maxc, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk_x5);
            if (int'(hc) == h && int'(vc) == v) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, int'(ok), 1);
    endtask

    task automatic wait_fs(input int n, input int maxc, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk_x5);
            if (fs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, int'(ok), 1);
    endtask

    // Requester: hold sel_req until sel_ack is seen, then drop it
    task automatic do_req(input logic [2:0] val, input int maxc, input bit want_fs, input string nm);
        bit ok;
        ok = 1'b0;
        step(1);
        sel_req = 1'b1;
        sel_val = val;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk_x5);
            if (sel_ack) begin
                ok = 1'b1;
                chk({nm, "_fs_with_ack"}, int'(frame_start), int'(want_fs));
                chk({nm, "_pattern"}, int'(pattern), int'(val));
                sel_req = 1'b0;
                break;
            end
            if (i == 20) chk({nm, "_pattern_held"}, int'(pattern), 0);
        end
        chk({nm, "_ack_seen"}, int'(ok), 1);
        sel_req = 1'b0;
    endtask

    initial begin : stim
        int n;
        rst_n   = 1'b1;
        enable  = 1'b0;
        sel_req = 1'b0;
        sel_val = '0;
        #1 rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;

        // Idle after reset: strobe every DIV cycles starting at cycle 4
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_x5);
            chk("idle_pix_stb", int'(pix_stb), int'(i % 5 == 4));
        end
        chk("idle_hc", int'(hc), 0);
        chk("idle_hsync", int'(hsync), 0);

        // Start frames, then a pattern change requested mid-frame
        step(1);
        enable = 1'b1;
        wait_fs(1, 50, "first_frame_start");
        step(200);
        do_req(3'd5, 1000, 1'b1, "run_req");
        wait_fs(3, 2000, "three_frames");
        if (fs_q.size() >= 3) begin
            chk("frame_period_a", fs_q[1] - fs_q[0], 650);
            chk("frame_period_b", fs_q[2] - fs_q[1], 650);
        end
        if (hs_rise_q.size() >= 2) chk("line_period", hs_rise_q[1] - hs_rise_q[0], 65);
        chk("hsync_len", last_hs_len, 15);
        chk("vsync_len", last_vs_len, 130);
        chk("de_first_hc", de_first_hc, 5);
        chk("de_first_vc", de_first_vc, 4);
        chk("de_fall_hc", de_fall_hc, 11);
        chk("max_hc", max_hc, 12);
        chk("vc_wrap", int'(vc_wrap), 1);

        // Request withdrawn before the boundary: no update, no ack
        wait_hv(0, 2, 700, "reach_line2");
        n = ack_cnt;
        step(1);
        sel_req = 1'b1;
        sel_val = 3'd3;
        step(50);
        sel_req = 1'b0;
        wait_fs(fs_q.size() + 1, 700, "after_withdraw_fs");
        step(10);
        chk("withdraw_pattern", int'(pattern), 5);
        chk("withdraw_no_ack", ack_cnt, n);

        // Disable mid-frame: frame completes then idles
        wait_hv(0, 5, 700, "reach_line5");
        step(1);
        enable = 1'b0;
        n = fs_q.size();
        begin : wait_idle
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 800; i++) begin
                @(negedge clk_x5);
                if (hc == 0 && vc == 0 && !hsync) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("drain_reaches_idle", int'(ok), 1);
        end
        chk("drain_no_fs", fs_q.size(), n);
        step(100);
        chk("idle_stays_no_fs", fs_q.size(), n);
        chk("idle_vsync", int'(vsync), 0);

        // Re-enable during drain: frames stay back to back
        step(1);
        enable = 1'b1;
        n = fs_q.size();
        wait_fs(n + 1, 20, "restart_fs");
        wait_hv(0, 3, 700, "reach_line3");
        step(1);
        enable = 1'b0;
        wait_hv(0, 6, 700, "reach_line6");
        step(1);
        enable = 1'b1;
        wait_fs(n + 3, 1400, "continuous_fs");
        if (fs_q.size() >= n + 3) begin
            chk("continuous_period_a", fs_q[n + 1] - fs_q[n], 650);
            chk("continuous_period_b", fs_q[n + 2] - fs_q[n + 1], 650);
        end

        // Disable during the very last pixel: straight to idle at the wrap
        wait_hv(12, 9, 700, "reach_last_pixel");
        enable = 1'b0;
        n = fs_q.size();
        step(20);
        chk("lastpix_idle_hc", int'(hc), 0);
        chk("lastpix_idle_hsync", int'(hsync), 0);
        chk("lastpix_no_fs", fs_q.size(), n);

        // Pattern request while idle is accepted immediately
        do_req(3'd2, 5, 1'b0, "idle_req");

        // Reset in the middle of active video
        step(1);
        enable = 1'b1;
        wait_hv(7, 5, 800, "reach_mid_frame");
        chk("pre_reset_de", int'(de), 1);
        step(1);
        rst_n = 1'b0;
        #1;
        chk("reset_hc", int'(hc), 0);
        chk("reset_vc", int'(vc), 0);
        chk("reset_de", int'(de), 0);
        chk("reset_pattern", int'(pattern), 0);
        chk("reset_pix_stb", int'(pix_stb), 0);
        step(3);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_x5);
            chk("post_reset_pix_stb", int'(pix_stb), int'(i == 4));
        end
        step(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
